serial_rx: RTL
==============

# serial_rx

Receiving end of the on-chip single-wire serial link driven by the `serial` block. Recovers UART-style frames and packs them into a multi-byte word for `bank`-side or loopback consumers:

- Frame format: idle-high line, start bit, 8 data bits LSB first, optional parity, stop bit.
- Also serves as a bench monitor that checks the `serial` output stream.

## Interface

Parameters:

- `CPB`, default 1: clock cycles per bit; legal range 1..255.
- `BYTES`, default 4: bytes packed per output word; legal range 1..16.

Ports:

- `clk`  in  1: the only clock; all logic rises on this edge.
- `rst`  in  1: asynchronous, active-high reset.
- `rx`  in  1: serial line; idle level is 1.
- `data`  out  8*BYTES: last completed word; first received byte sits in `data[7:0]`.
- `valid`  out  1: one-cycle pulse when `data` updates.
- `byte_cnt`  out  4: number of bytes held in the current partial word.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `frame_err`  out  1: one-cycle pulse on a bad stop bit, or on a bad parity bit when parity is compiled in.

## Operation

- State sequence: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. An error path goes to WAIT_HIGH.
- **IDLE:** when `rx`=0, go to START. Call the detection cycle t0.
- **Sample points:** the half-bit offset is H = (CPB-1)/2, using integer division.
  - Start bit is sampled at t0+H.
  - Data bit i (0..7) is sampled at t0+H+(i+1)*CPB.
  - Parity is sampled at t0+H+9*CPB.
  - Stop is sampled at t0+H+9*CPB without parity, or t0+H+10*CPB with parity.
- **START:** if the start sample is 1, treat it as a glitch and return to IDLE with no flag. If it is 0, go to DATA.
- **DATA:** shift each sampled bit into an 8-bit shift register, LSB first. A 3-bit bit counter moves to the next state after bit 7.
- **STOP:**
  - Sample = 1: the byte is accepted. Write it into word-buffer lane `byte_cnt`, then increment `byte_cnt`.
  - Sample = 0: pulse `frame_err`, discard the partial word (`byte_cnt`<=0), go to WAIT_HIGH.
- **Word completion:** when an accepted byte makes `byte_cnt` reach BYTES:
  - copy the buffer to `data`;
  - pulse `valid`;
  - set `byte_cnt` to 0.
- **WAIT_HIGH:** stay until `rx`=1, then go to IDLE. This prevents false start detection on a stuck-low line.
- **Reset:** asserting `rst` at any time does all of the following:
  - aborts any frame in progress;
  - clears `data`, `valid`, `frame_err`, `busy`, `byte_cnt` and the internal counters to 0;
  - puts the FSM in IDLE.
- **Reset release:** the first edge that can be detected is a 1->0 transition seen in IDLE after `rst` falls.
- **`data` stability:** `data` holds its value between `valid` pulses and never shows a partial word.

## Timing

- Outputs `valid`, `frame_err` and `data` are registered. All three update on the edge after the stop-bit sample cycle.
- **CPB=1, no parity:**
  - t0: start seen. Start is confirmed in the same cycle because H=0.
  - Bits are sampled at t0+1..t0+8 and stop at t0+9.
  - `valid` or `frame_err` is high during t0+10.
- **Back-to-back frames:** the FSM is in IDLE at t0+10. A new start bit low at t0+10 is accepted.
- **`busy`:** high from t0+1 through the stop-sample cycle, plus any cycles spent in WAIT_HIGH.
- **Timing of `byte_cnt`:** updates on the same edge as `valid`.
- **`valid` vs `frame_err`:** never both high in one cycle.

## Configuration

- Macro: `SERIAL_RX_PARITY_EN`.
- **Defined:**
  - An even-parity bit follows the data bits; the frame is 11 bits.
  - PARITY state samples it at t0+H+9*CPB.
  - On a mismatch, the FSM still waits through the stop sample, then acts as for a bad stop bit: pulses `frame_err`, discards the partial word and goes to WAIT_HIGH.
- **Undefined:**
  - The frame is 10 bits.
  - No PARITY state exists; its logic and state encoding are not synthesised.

## Test plan

- **Reset values:** CPB=1, BYTES=4. Hold `rst` high -> all outputs are 0. Release with `rx`=1 for 20 cycles -> `busy`=0, no pulses.
- **Single word:** send frames 0x11, 0x22, 0x33, 0x44 back-to-back with no idle gap -> exactly one `valid` pulse, `data`=0x44332211, and `byte_cnt` steps 1, 2, 3, 0.
- **Bad stop:** send 0xA5 with stop=0 -> `frame_err` pulses at t0+10. `byte_cnt` goes to 0. With `rx` held low 5 cycles and then high, no new frame starts until `rx` rises.
- **Glitch rejection:** CPB=8, `rx` low for 2 cycles -> START sample at t0+3 reads 1, return to IDLE, no pulses. A following full 0x5A frame plus 3 more bytes -> `data[7:0]`=0x5A.
- **Reset mid-frame:** assert `rst` after bit 3 of the second byte -> `byte_cnt`=0, `busy`=0. The next 4 frames produce a word containing only the new bytes.
- **Parity (`SERIAL_RX_PARITY_EN`):**
  - 0x03 with parity 0 -> accepted.
  - 0x07 with parity 0 -> `frame_err` and no `valid`.

Source files
------------

// File: rtl/serial_rx.sv
// serial_rx: UART-style frame receiver (start, 8 data bits LSB first,
// optional even parity, stop) that packs BYTES accepted bytes into one word.
// Optional feature macro: SERIAL_RX_PARITY_EN (adds an even-parity bit
// between the data bits and the stop bit).
module serial_rx #(
    parameter int CPB   = 1,
    parameter int BYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [8*BYTES-1:0] data,
    output logic               valid,
    output logic [3:0]         byte_cnt,
    output logic               busy,
    output logic               frame_err
);
    // Sample point sits H cycles into each bit; counters are reloaded so
    // that the sample happens when cnt reaches zero.
    localparam int         H         = (CPB - 1) / 2;
    localparam logic [7:0] BIT_LD    = 8'(CPB - 1);
    localparam logic [7:0] HALF_LD   = (H == 0) ? 8'd0 : 8'(H - 1);
    localparam logic [3:0] LAST_LANE = 4'(BYTES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
`ifdef SERIAL_RX_PARITY_EN
        , PARITY  = 3'd5
`endif
    } state_t;

    state_t               state, state_nxt;
    logic [7:0]           cnt;
    logic [2:0]           bit_cnt;
    logic [7:0]           shreg;
    logic [BYTES-1:0][7:0] wbuf, word_nxt;
    logic                 tick;
    logic                 frame_ok;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_err;
`endif

    assign tick = (cnt == 8'd0);

    // A frame is good only if the stop bit is high (and parity matched).
`ifdef SERIAL_RX_PARITY_EN
    assign frame_ok = rx && !par_err;
`else
    assign frame_ok = rx;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; with H=0 the start bit is confirmed on detection
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx) state_nxt = (H == 0) ? DATA : START;
            START:     if (tick) state_nxt = rx ? IDLE : DATA;
`ifdef SERIAL_RX_PARITY_EN
            DATA:      if (tick && bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY:    if (tick) state_nxt = STOP;
`else
            DATA:      if (tick && bit_cnt == 3'd7) state_nxt = STOP;
`endif
            STOP:      if (tick) state_nxt = frame_ok ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output decode: busy flag and the word as it would look with the
    // current byte merged into lane byte_cnt
    always_comb begin
        busy     = (state != IDLE);
        word_nxt = wbuf;
        for (int i = 0; i < BYTES; i++)
            if (byte_cnt == 4'(i)) word_nxt[i] = shreg;
    end

    // Datapath: bit timing, shift register, word buffer and pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            wbuf      <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            byte_cnt  <= '0;
`ifdef SERIAL_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: if (!rx) begin
                    cnt     <= (H == 0) ? BIT_LD : HALF_LD;
                    bit_cnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
                    par_err <= 1'b0;
`endif
                end
                START: cnt <= tick ? BIT_LD : cnt - 8'd1;
                DATA: begin
                    cnt <= tick ? BIT_LD : cnt - 8'd1;
                    if (tick) begin
                        shreg   <= {rx, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    cnt <= tick ? BIT_LD : cnt - 8'd1;
                    if (tick) par_err <= rx ^ (^shreg);
                end
`endif
                STOP: begin
                    cnt <= tick ? BIT_LD : cnt - 8'd1;
                    if (tick) begin
                        if (frame_ok) begin
                            if (byte_cnt == LAST_LANE) begin
                                data     <= word_nxt;
                                valid    <= 1'b1;
                                byte_cnt <= '0;
                            end else begin
                                wbuf     <= word_nxt;
                                byte_cnt <= byte_cnt + 4'd1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            byte_cnt  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
